// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver front end with 16x oversampling.
// The raw line is synchronised, a start edge aligns a baud divider, each
// bit is majority-voted from three mid-bit samples, and framed bytes are
// delivered with status, overrun and frame-error reporting.
module uart_rx_oversample #(
    parameter int DIV_NUM = 325,
    parameter int DIV_W   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_STATUS,
    input  logic       RX_ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_NUM - 1);

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_d_r;
    logic [DIV_W-1:0] div_r;
    logic [3:0]       s_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic             samp7_r;
    logic             samp8_r;
    logic [7:0]       shreg_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             rx_status_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;

    logic             fall_s;
    logic             tick_s;
    logic             vote_s;
    logic             vote_tick_s;
    logic             end_tick_s;
    logic             shift_s;
    logic             bit_clr_s;
    logic             bit_inc_s;
    logic             good_s;
    logic             ferr_s;

    assign fall_s      = rx_d_r & ~rx_sync_r;
    assign tick_s      = (state_r != ST_IDLE) && (div_r == DIV_LAST);
    assign vote_s      = maj3(samp7_r, samp8_r, rx_sync_r);
    assign vote_tick_s = tick_s && (s_cnt_r == 4'd9);
    assign end_tick_s  = tick_s && (s_cnt_r == 4'd15);

    // Two-stage synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_d_r    <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
            rx_d_r    <= rx_sync_r;
        end
    end

    // Baud divider: parked at zero while idle so the bit phase starts at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= '0;
        end else if (state_r == ST_IDLE) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Oversample counter: 16 ticks per bit, cleared while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_cnt_r <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            s_cnt_r <= 4'd0;
        end else if (tick_s) begin
            s_cnt_r <= s_cnt_r + 4'd1;
        end else begin
            s_cnt_r <= s_cnt_r;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp7_r <= 1'b1;
            samp8_r <= 1'b1;
        end else begin
            if (tick_s && (s_cnt_r == 4'd7)) begin
                samp7_r <= rx_sync_r;
            end
            if (tick_s && (s_cnt_r == 4'd8)) begin
                samp8_r <= rx_sync_r;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        shift_s      = 1'b0;
        bit_clr_s    = 1'b0;
        bit_inc_s    = 1'b0;
        good_s       = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (vote_tick_s && vote_s) begin
                    // Line was high again mid start bit: treat as a glitch.
                    state_next_s = ST_IDLE;
                end else if (end_tick_s) begin
                    state_next_s = ST_DATA;
                    bit_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                shift_s   = vote_tick_s;
                bit_inc_s = end_tick_s;
                if (end_tick_s && (bit_cnt_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (vote_tick_s) begin
                    // Leave mid stop bit so a following start edge is not missed.
                    state_next_s = ST_IDLE;
                    good_s       = vote_s;
                    ferr_s       = ~vote_s;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Data shift register (LSB first on the line) and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else begin
            if (shift_s) begin
                shreg_r <= {vote_s, shreg_r[7:1]};
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (bit_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Delivered byte, pulses and busy indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= good_s;
            frame_err_r <= ferr_s;
            busy_r      <= (state_next_s != ST_IDLE);
            if (good_s) begin
                rx_data_r <= shreg_r;
            end
        end
    end

    // Status and overrun: a new byte wins over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_status_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (good_s) begin
            rx_status_r <= 1'b1;
            overrun_r   <= overrun_r | rx_status_r;
        end else if (RX_ACK) begin
            rx_status_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rx_status_r <= rx_status_r;
            overrun_r   <= overrun_r;
        end
    end

    assign RX_DATA   = rx_data_r;
    assign RX_VALID  = rx_valid_r;
    assign RX_STATUS = rx_status_r;
    assign FRAME_ERR = frame_err_r;
    assign OVERRUN   = overrun_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample with DIV_NUM=4 (one bit = 64 clk).
// A frame-level model predicts each delivered byte or framing error and
// its arrival cycle; a per-cycle compare process tracks data/status/overrun.
module tb_uart_rx_oversample;

    localparam int BIT_CLK = 64;
    localparam int LAT     = 619;

    logic       clk;
    logic       reset;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_STATUS;
    logic       RX_ACK;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t expq[$];

    logic [7:0] m_data;
    logic       m_stat;
    logic       m_ovr;

    uart_rx_oversample #(.DIV_NUM(4), .DIV_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_STATUS (RX_STATUS),
        .RX_ACK    (RX_ACK),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the frame-level model.
    initial begin : cmp
        ev_t  e;
        logic ack_e;
        logic got_v;
        bit   overdue;
        bit   in_win;
        forever begin
            @(posedge clk);
            ack_e = RX_ACK;
            cyc++;
            @(negedge clk);
            if (reset) begin
                m_data = 8'h00;
                m_stat = 1'b0;
                m_ovr  = 1'b0;
                expq.delete();
                chk("reset_valid", RX_VALID, 0);
                chk("reset_ferr", FRAME_ERR, 0);
                chk("reset_busy", BUSY, 0);
            end else begin
                got_v = 1'b0;
                chk("spurious_event", (RX_VALID || FRAME_ERR) && (expq.size() == 0), 0);
                if ((RX_VALID || FRAME_ERR) && (expq.size() > 0)) begin
                    e = expq.pop_front();
                    chk("event_kind", {RX_VALID, FRAME_ERR}, e.is_err ? 2'b01 : 2'b10);
                    in_win = (cyc >= e.due - 1) && (cyc <= e.due + 1);
                    chk("event_latency_window", in_win, 1);
                    if (!e.is_err) begin
                        got_v  = 1'b1;
                        m_ovr  = m_ovr | m_stat;
                        m_stat = 1'b1;
                        m_data = e.data;
                    end
                end
                if (!got_v && ack_e) begin
                    m_stat = 1'b0;
                    m_ovr  = 1'b0;
                end
                overdue = (expq.size() > 0) && (cyc > expq[0].due + 1);
                chk("event_overdue", overdue, 0);
                if (overdue) begin
                    e = expq.pop_front();
                end
            end
            chk("rx_data", RX_DATA, m_data);
            chk("rx_status", RX_STATUS, m_stat);
            chk("overrun", OVERRUN, m_ovr);
        end
    end

    // Drive one 8N1 frame; caller sits 1 time unit after a clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit spikes, input int abort_t);
        int   c0;
        ev_t  e;
        logic v;
        int   k;
        c0 = cyc;
        if (abort_t == 0) begin
            e.due    = c0 + LAT;
            e.is_err = ~stop;
            e.data   = b;
            expq.push_back(e);
        end
        for (int t = 0; t < 10 * BIT_CLK; t++) begin
            if ((abort_t != 0) && (t == abort_t)) begin
                chk("busy_mid_frame", BUSY, 1);
                reset   = 1'b1;
                UART_RX = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                reset = 1'b0;
                return;
            end
            k = t / BIT_CLK;
            if (k == 0) v = 1'b0;
            else if (k == 9) v = stop;
            else v = b[k-1];
            if (spikes && (k >= 1) && (k <= 8) && ((t % BIT_CLK) == 36)) v = ~v;
            UART_RX = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        RX_ACK = 1'b1;
        @(posedge clk);
        #1;
        RX_ACK = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        UART_RX = 1'b1;
        RX_ACK  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_lit", RX_DATA, 8'h00);
        chk("reset_status_lit", RX_STATUS, 0);
        reset = 1'b0;
        idle(10);

        // Single byte.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        chk("a5_data_lit", RX_DATA, 8'hA5);
        chk("a5_status_lit", RX_STATUS, 1);
        chk("a5_overrun_lit", OVERRUN, 0);
        idle(20);
        ack_pulse();
        chk("ack_clears_status", RX_STATUS, 0);
        idle(10);

        // Back-to-back, no ack between: second byte overruns.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        chk("b2b_data_lit", RX_DATA, 8'hFF);
        chk("b2b_overrun_lit", OVERRUN, 1);
        idle(20);

        // Framing error, line then held low: no new frame without an edge.
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        idle(100);
        chk("ferr_data_kept", RX_DATA, 8'hFF);
        chk("ferr_status_kept", RX_STATUS, 1);
        ack_pulse();
        chk("ack_clears_overrun", OVERRUN, 0);
        chk("ack_clears_status2", RX_STATUS, 0);
        idle(10);

        // 20-clk glitch: false start.
        UART_RX = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("glitch_busy_high", BUSY, 1);
        idle(80);
        chk("glitch_busy_low", BUSY, 0);
        chk("glitch_status", RX_STATUS, 0);

        // Ack coincident with the valid pulse: the new byte wins.
        fork
            send_frame(8'h96, 1'b1, 1'b0, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                RX_ACK = 1'b1;
                @(posedge clk);
                #1;
                RX_ACK = 1'b0;
            end
        join
        chk("ack_same_cycle_status", RX_STATUS, 1);
        chk("ack_same_cycle_overrun", OVERRUN, 0);
        chk("ack_same_cycle_data", RX_DATA, 8'h96);
        idle(20);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'hE7, 1'b1, 1'b0, 5 * BIT_CLK + 20);
        chk("post_reset_data", RX_DATA, 8'h00);
        chk("post_reset_busy", BUSY, 0);
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        chk("after_reset_5a", RX_DATA, 8'h5A);
        idle(20);

        // Single-clock spikes at mid-bit are voted out.
        send_frame(8'hC3, 1'b1, 1'b1, 0);
        chk("spike_c3", RX_DATA, 8'hC3);
        idle(20);

        for (int i = 0; (i < 2000) && (expq.size() > 0); i++) @(posedge clk);
        chk("events_drained", expq.size(), 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
